// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
// PROG_LOADER_CSUM_EN adds the CSUM state to the loader state set.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
`ifdef PROG_LOADER_CSUM_EN
        CSUM = 3'd3,
`endif
        DONE = 3'd4,
        ERR  = 3'd5
    } loader_state_t;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [31:0] NOP_INSTR = 32'hE1A00000;

    // A length byte is usable only if it names 1..depth words.
    function automatic logic len_in_range(input logic [7:0] len, input int unsigned depth);
        return (len != 8'd0) && ({1'b0, len} <= 9'(depth));
    endfunction

endpackage

// File: rtl/prog_loader_instr_ram.sv
// Instruction store: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module instr_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: SYNC, length, little-endian words, optional checksum.
// Define PROG_LOADER_CSUM_EN to enable the trailing checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic        cpu_reset,
    output logic        loaded,
    output logic        load_error,
    output logic [7:0]  word_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    loader_state_t state, next_state;

    logic [7:0]  n_words;
    logic [1:0]  byte_idx;
    logic [23:0] pack;
`ifdef PROG_LOADER_CSUM_EN
    logic [7:0]  csum;
`endif

    logic        word_done;
    logic        last_word;
    logic [31:0] ram_rdata;
    logic        pc_unused;

    assign word_done = (state == DATA) && rx_valid && (byte_idx == 2'd3);
    assign last_word = (({1'b0, word_count} + 9'd1) == {1'b0, n_words});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (rx_data == SYNC_BYTE) next_state = LEN;
                end
                LEN: begin
                    next_state = len_in_range(rx_data, DEPTH) ? DATA : ERR;
                end
                DATA: begin
                    if (word_done && last_word) begin
`ifdef PROG_LOADER_CSUM_EN
                        next_state = CSUM;
`else
                        next_state = DONE;
`endif
                    end
                end
`ifdef PROG_LOADER_CSUM_EN
                CSUM: begin
                    next_state = (rx_data == csum) ? DONE : ERR;
                end
`endif
                DONE, ERR: begin
                    if (rx_data == SYNC_BYTE) next_state = LEN;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Packer, counters and checksum advance only on accepted bytes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_words    <= '0;
            byte_idx   <= '0;
            pack       <= '0;
            word_count <= '0;
            load_error <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
            csum       <= '0;
`endif
        end else begin
            if (rx_valid) begin
                case (state)
                    LEN: begin
                        n_words    <= rx_data;
                        word_count <= '0;
                        byte_idx   <= '0;
`ifdef PROG_LOADER_CSUM_EN
                        csum       <= '0;
`endif
                    end
                    DATA: begin
                        byte_idx <= byte_idx + 2'd1;
                        pack     <= {rx_data, pack[23:8]};
`ifdef PROG_LOADER_CSUM_EN
                        csum     <= csum + rx_data;
`endif
                        if (byte_idx == 2'd3) begin
                            word_count <= word_count + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
            if (state != LEN && next_state == LEN) begin
                load_error <= 1'b0;
            end else if (state != ERR && next_state == ERR) begin
                load_error <= 1'b1;
            end
        end
    end

    instr_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (word_done),
        .waddr (word_count[AW-1:0]),
        .wdata ({rx_data, pack}),
        .raddr (PC[AW+1:2]),
        .rdata (ram_rdata)
    );

    assign pc_unused   = ^PC[1:0];
    assign Instruction = (PC[31:AW+2] != '0) ? NOP_INSTR : ram_rdata;
    assign cpu_reset   = (state != DONE);
    assign loaded      = (state == DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader; follows PROG_LOADER_CSUM_EN.
module tb_prog_loader;

    localparam int unsigned DEPTH = 16;
`ifdef PROG_LOADER_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif
    localparam logic [7:0]  SYNC = 8'hA5;
    localparam logic [31:0] NOP  = 32'hE1A00000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [31:0] PC = '0;
    logic [31:0] Instruction;
    logic        cpu_reset;
    logic        loaded;
    logic        load_error;
    logic [7:0]  word_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] model_ram [DEPTH];
    bit          model_valid [DEPTH];
    bit          model_loaded = 1'b0;

    always #5 clk = ~clk;

    prog_loader #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .PC          (PC),
        .Instruction (Instruction),
        .cpu_reset   (cpu_reset),
        .loaded      (loaded),
        .load_error  (load_error),
        .word_count  (word_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic check_status(input bit exp_loaded, input bit exp_err, input int unsigned exp_wc);
        check("cpu_reset", 32'(cpu_reset), 32'(!exp_loaded));
        check("loaded", 32'(loaded), 32'(exp_loaded));
        check("load_error", 32'(load_error), 32'(exp_err));
        check("word_count", 32'(word_count), exp_wc);
    endtask

    task automatic check_ram();
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (model_valid[i]) begin
                PC = 32'(i) * 32'd4 + 32'($urandom_range(0, 3));
                #1;
                check("ram_read", Instruction, model_ram[i]);
            end
        end
        PC = 32'(4 * DEPTH);
        #1;
        check("nop_boundary", Instruction, NOP);
        PC = 32'(4 * DEPTH) + 32'($urandom_range(0, 32'h7FFF_FFFF));
        #1;
        check("nop_far", Instruction, NOP);
        PC = '0;
    endtask

    task automatic run_load(input int unsigned n, input bit bad_csum, input int unsigned n_garbage,
                            input bit b2b, input bit use_w0, input logic [31:0] w0);
        logic [31:0] words [$];
        logic [7:0]  stream [$];
        logic [31:0] w;
        logic [7:0]  g;
        logic [7:0]  sum;
        bit          ok;
        bit          exp_rst;
        sum = '0;
        for (int unsigned i = 0; i < n_garbage; i++) begin
            g = 8'($urandom);
            if (g == SYNC) g = 8'h11;
            stream.push_back(g);
        end
        stream.push_back(SYNC);
        stream.push_back(8'(n));
        for (int unsigned i = 0; i < n; i++) begin
            w = (use_w0 && i == 0) ? w0 : $urandom;
            words.push_back(w);
            for (int k = 0; k < 4; k++) begin
                stream.push_back(w[8*k +: 8]);
                sum = sum + w[8*k +: 8];
            end
        end
        if (CSUM_EN) stream.push_back(bad_csum ? sum + 8'($urandom_range(1, 255)) : sum);
        ok = !(CSUM_EN && bad_csum);
        for (int i = 0; i < stream.size(); i++) begin
            send_byte(stream[i]);
            if (i < int'(n_garbage)) exp_rst = !model_loaded;
            else if (i == stream.size() - 1) exp_rst = !ok;
            else exp_rst = 1'b1;
            check("cpu_reset_stream", 32'(cpu_reset), 32'(exp_rst));
            if (!b2b) idle($urandom_range(0, 2));
        end
        for (int unsigned i = 0; i < n; i++) begin
            model_ram[i]   = words[i];
            model_valid[i] = 1'b1;
        end
        model_loaded = ok;
        check_status(ok, !ok, n);
        check_ram();
    endtask

    task automatic run_bad_len(input logic [7:0] len);
        send_byte(SYNC);
        check("cpu_reset_sync", 32'(cpu_reset), 32'd1);
        send_byte(len);
        check("cpu_reset_len", 32'(cpu_reset), 32'd1);
        idle(1);
        model_loaded = 1'b0;
        check_status(1'b0, 1'b1, 0);
        check_ram();
    endtask

    task automatic run_abort();
        send_byte(SYNC);
        send_byte(8'd4);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'($urandom));
            check("cpu_reset_pre_abort", 32'(cpu_reset), 32'd1);
        end
        reset = 1'b0;
        #1;
        model_loaded = 1'b0;
        check_status(1'b0, 1'b0, 0);
        for (int i = 0; i < 2; i++) begin
            idle(1);
            check("cpu_reset_abort", 32'(cpu_reset), 32'd1);
        end
        reset = 1'b1;
        idle(1);
        check_status(1'b0, 1'b0, 0);
        check_ram();
    endtask

    initial begin
        idle(3);
        check_status(1'b0, 1'b0, 0);
        reset = 1'b1;
        idle(2);

        run_load(1, 1'b0, 0, 1'b0, 1'b1, 32'hE3A00000);
        run_load(2, 1'b1, 0, 1'b0, 1'b0, '0);
        run_load(3, 1'b0, 2, 1'b0, 1'b0, '0);
        run_bad_len(8'd0);
        run_bad_len(8'(DEPTH + 1));
        run_load(DEPTH, 1'b0, 2, 1'b1, 1'b0, '0);
        run_abort();
        run_load(5, 1'b0, 0, 1'b1, 1'b0, '0);
        for (int r = 0; r < 6; r++) begin
            run_load($urandom_range(1, DEPTH), ($urandom % 4) == 0, $urandom_range(0, 3),
                     1'($urandom % 2), 1'b0, '0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DEPTH, default 64, SHALL set the instruction RAM size in 32-bit words; it SHALL be a power of two, 2..256.
REQ-002 Port: clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: rx_data  input  8  received serial byte.
REQ-005 Port: rx_valid  input  1  rx_data is valid this cycle; the byte SHALL be consumed on any cycle with rx_valid=1, and there is no backpressure.
REQ-006 Port: PC  input  32  processor fetch address (byte address).
REQ-007 Port: Instruction  output  32  instruction word fed to the processor.
REQ-008 Port: cpu_reset  output  1  active-high processor reset.
REQ-009 Port: loaded  output  1  a valid program is resident.
REQ-010 Port: load_error  output  1  the last load failed.
REQ-011 Port: word_count  output  8  number of words written in the current or last load.

Function
REQ-012 The FSM SHALL have the states IDLE, LEN, DATA, CSUM, DONE and ERR.
REQ-013 IDLE: a byte equal to SYNC (0xA5) SHALL go to LEN; any other byte SHALL be ignored.
REQ-014 LEN: the byte SHALL be latched as N, word_count SHALL clear, and the FSM SHALL go to DATA if 1<=N<=DEPTH, otherwise to ERR.
REQ-015 DATA: bytes SHALL be packed little-endian (first byte -> [7:0]).
- RAM[word_count] SHALL be written on the edge that accepts the 4th byte of each word, and word_count SHALL increment on that same edge.
- After word N-1 is written, the FSM SHALL go to CSUM.
REQ-016 CSUM: if the byte equals the 8-bit modulo-256 sum of all 4*N data bytes, the FSM SHALL go to DONE; otherwise it SHALL go to ERR.
REQ-017 DONE and ERR: a SYNC byte SHALL go to LEN, which starts a reload; other bytes SHALL be ignored.
REQ-018 cpu_reset SHALL equal (state != DONE), decoded only from the state register, so it is glitch-free.
- The processor therefore SHALL be held in reset for the whole load and SHALL be released on the first cycle in DONE.
REQ-019 loaded SHALL be 1 only in DONE.
REQ-020 load_error SHALL be set on entry to ERR and cleared on entry to LEN.
REQ-021 Instruction SHALL be a combinational read of RAM[PC[log2(DEPTH)+1:2]].
- PC[1:0] SHALL be ignored.
- If PC >= 4*DEPTH, Instruction SHALL be NOP (0xE1A00000).
REQ-022 Reads SHALL return old data during the write cycle; no forwarding is required because the processor is in reset then.
REQ-023 rx_valid held high SHALL consume one byte per cycle, with no byte dropped at state boundaries.
REQ-024 A failed reload SHALL leave the partially written RAM; only loaded=0 marks it invalid.

Reset
REQ-025 While reset=0, the block SHALL hold: state=IDLE, cpu_reset=1, loaded=0, load_error=0, word_count=0, byte index=0, checksum accumulator=0, N=0.
REQ-026 RAM contents SHALL NOT be reset.
REQ-027 Assertion of reset mid-load SHALL abort the load immediately, and the next load SHALL restart from IDLE.

Configuration
REQ-028 The macro PROG_LOADER_CSUM_EN SHALL control the checksum feature.
- Defined: the CSUM state and checksum accumulator SHALL exist as described in REQ-016.
- Undefined: CSUM and the accumulator SHALL be omitted, and the FSM SHALL go from DATA directly to DONE after word N-1 is written.

Structure
REQ-029 Package prog_loader_pkg SHALL hold the state enum (loader_state_t), SYNC_BYTE=8'hA5 and NOP_INSTR=32'hE1A00000.
REQ-030 Sub-module instr_ram (DEPTH x 32, one synchronous write port, one asynchronous read port) SHALL hold the program.
- The FSM, byte packer and checksum SHALL be in prog_loader.

Verification
REQ-031 Stream A5,01,00,00,A0,E3,83 (checksum defined) -> RAM[0]=E3A00000, word_count=1, DONE, cpu_reset drops on the cycle after the checksum byte, and PC=0 gives Instruction=E3A00000.
REQ-032 Stream A5,02 plus 8 data bytes plus a wrong checksum -> ERR, load_error=1, loaded=0, cpu_reset=1; then a valid stream -> DONE and load_error=0.
REQ-033 LEN byte 00, and separately LEN=DEPTH+1 -> ERR with no RAM write; LEN=DEPTH with a full stream -> word_count=DEPTH, and the last word is readable at PC=4*(DEPTH-1).
REQ-034 Bytes 11,22 before A5 in IDLE -> ignored; back-to-back rx_valid for the whole stream -> same result as a spaced stream.
REQ-035 reset pulled low after 3 data bytes, then a full valid stream -> correct load, cpu_reset=1 throughout the abort; PC=4*DEPTH -> Instruction=E1A00000.
REQ-036 Build without PROG_LOADER_CSUM_EN, stream A5,01 plus 4 bytes -> DONE on the edge accepting the 4th data byte.
